regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the next-generation core. Replaces the single-read-pair, single-write GPR array.
- Adds configurable width, depth and read-port count, two write ports with fixed priority, hardwired zero register, and a per-register pending-write scoreboard.
- Sits between decode (reads, issue) and writeback (ALU port 0, load/mul port 1). Feeds operands and hazard flags to the issue stage.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- NREAD, 3, number of independent read ports, 1..8.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NREAD*AW  read addresses, port k at bits [k*AW +: AW].
- rd_data  out  NREAD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
- rd_busy  out  NREAD  scoreboard busy bit of each read address.
- wen0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- wen1  in  1  write enable, port 1.
- waddr1  in  AW  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- issue_en  in  1  mark issue_addr pending.
- issue_addr  in  AW  destination register of the issuing instruction.
- flush  in  1  clear all busy bits.
- busy_vec  out  DEPTH  full scoreboard, bit i = register i pending.

Behaviour:
- Reset (async, rst_n=0): all registers and all busy bits go to 0 immediately. rd_data then reads 0, rd_busy=0, busy_vec=0. Deassertion takes effect at the next clk edge.
- Reads are combinational from the array. Latency 0 relative to address; written data visible the cycle after the write edge, unless bypass is enabled (see Optional Feature).
- Writes commit on the rising clk edge when wenX=1.
- wen0 and wen1 to the same address in the same cycle: port 1 wins, port 0 data dropped. Different addresses: both commit.
- ZERO_REG=1: writes to address 0 are ignored; rd_data for address 0 is always 0; busy bit 0 is forced 0. ZERO_REG=0: address 0 is an ordinary register.
- Scoreboard, per register i, evaluated at each clk edge in priority order (highest first):
  1. flush=1: busy[i] <= 0; issue_en is ignored this cycle.
  2. issue_en=1 and issue_addr==i: busy[i] <= 1 (a new pending write overrides a same-cycle retire).
  3. (wen0 and waddr0==i) or (wen1 and waddr1==i): busy[i] <= 0.
  4. Otherwise busy[i] holds.
- rd_busy[k] = busy_vec[rd_addr[k]], combinational.
- A write to a non-busy register is legal: data commits, busy stays 0.
- Reset mid-operation: pending writes are lost. No write or issue on the edge that coincides with active reset takes effect.
- No X propagation: out-of-range addresses cannot occur because DEPTH = 2^AW.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If wen1 and waddr1==rd_addr[k], rd_data[k]=wdata1. Else if wen0 and waddr0==rd_addr[k], rd_data[k]=wdata0. Else array value. The zero-register rule still applies; rd_busy is unaffected.
- Not defined: rd_data comes from the array only; same-cycle writes are visible the next cycle.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse rst_n low mid-cycle -> rd_data for r5 is 0 immediately (asynchronous), busy_vec=0.
- Dual write, same address: wen0 r7=0x11111111 and wen1 r7=0x22222222 in one cycle -> next cycle r7 reads 0x22222222. Different addresses r3/r4 -> both commit.
- Zero register: ZERO_REG=1, write r0=0xFFFFFFFF and issue r0 -> r0 reads 0, busy_vec[0]=0. Repeat with ZERO_REG=0 -> r0 reads 0xFFFFFFFF.
- Scoreboard: issue r9 -> rd_busy=1 on the next cycle. Same cycle as a write to r9: issue r9 and wen0 r9 -> busy stays 1. Then wen1 r9 alone -> busy clears. Flush with issue r12 -> busy_vec=0.
- Read ports, NREAD=3: read r1, r2, r3 holding 1, 2, 3 simultaneously -> outputs 1, 2, 3 on the correct slices. All three ports read r2 -> all output 2.
- Bypass: wen0 r6=0xCAFE while reading r6. With REGFILE_BYPASS_EN -> 0xCAFE the same cycle. Without it -> old value, then 0xCAFE the next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports, two prioritised write ports,
// optional zero register and a per-register pending-write scoreboard.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NREAD    = 3,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    wen0,
    input  logic [AW-1:0]           waddr0,
    input  logic [DATA_W-1:0]       wdata0,
    input  logic                    wen1,
    input  logic [AW-1:0]           waddr1,
    input  logic [DATA_W-1:0]       wdata1,
    input  logic                    issue_en,
    input  logic [AW-1:0]           issue_addr,
    input  logic                    flush,
    output logic [DEPTH-1:0]        busy_vec
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [DEPTH-1:0]  wr0_hit;
    logic [DEPTH-1:0]  wr1_hit;
    logic [DEPTH-1:0]  iss_hit;

    // One-hot decode of both write ports and the issue port; register 0 is masked when hardwired
    always_comb begin
        wr0_hit = '0;
        wr1_hit = '0;
        iss_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wr0_hit[i] = wen0     && (waddr0     == AW'(i));
            wr1_hit[i] = wen1     && (waddr1     == AW'(i));
            iss_hit[i] = issue_en && (issue_addr == AW'(i));
        end
        if (ZERO_EN) begin
            wr0_hit[0] = 1'b0;
            wr1_hit[0] = 1'b0;
            iss_hit[0] = 1'b0;
        end
    end

    // Register array; port 1 takes precedence on an address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr1_hit[i]) begin
                    mem[i] <= wdata1;
                end else if (wr0_hit[i]) begin
                    mem[i] <= wdata0;
                end
            end
        end
    end

    // Scoreboard next state: flush, then issue (beats a same-cycle retire), then retire
    always_comb begin
        busy_nxt = busy;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (flush) begin
                busy_nxt[i] = 1'b0;
            end else if (iss_hit[i]) begin
                busy_nxt[i] = 1'b1;
            end else if (wr0_hit[i] || wr1_hit[i]) begin
                busy_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

    // Read ports
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] val;

        assign ra = rd_addr[k*AW +: AW];

        always_comb begin
            val = mem[ra];
`ifdef REGFILE_BYPASS_EN
            if (wen1 && (waddr1 == ra)) begin
                val = wdata1;
            end else if (wen0 && (waddr0 == ra)) begin
                val = wdata0;
            end
`endif
            if (ZERO_EN && (ra == '0)) begin
                val = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = val;
        assign rd_busy[k]                  = busy[ra];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: one DUT with the zero register,
// one without, sharing all inputs.
module tb_regfile_mp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned NREAD  = 3;
    localparam int unsigned AW     = 5;

    logic                    clk;
    logic                    rst_n;
    logic [NREAD*AW-1:0]     rd_addr;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic [NREAD*DATA_W-1:0] rd_data_nz;
    logic [NREAD-1:0]        rd_busy;
    logic [NREAD-1:0]        rd_busy_nz;
    logic                    wen0;
    logic [AW-1:0]           waddr0;
    logic [DATA_W-1:0]       wdata0;
    logic                    wen1;
    logic [AW-1:0]           waddr1;
    logic [DATA_W-1:0]       wdata1;
    logic                    issue_en;
    logic [AW-1:0]           issue_addr;
    logic                    flush;
    logic [DEPTH-1:0]        busy_vec;
    logic [DEPTH-1:0]        busy_vec_nz;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NREAD(NREAD), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .busy_vec(busy_vec)
    );

    regfile_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NREAD(NREAD), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nz), .rd_busy(rd_busy_nz),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .busy_vec(busy_vec_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
        wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        rd_addr = {a2, a1, a0};
    endtask

    task automatic test_reset();
        checks++;
        if (busy_vec !== '0) begin
            errors++; $display("FAIL reset_busy: got %h exp 0", busy_vec);
        end
        set_rd(5'd5, 5'd0, 5'd31); #1;
        checks++;
        if (rd_data !== '0) begin
            errors++; $display("FAIL reset_rd_data: got %h exp 0", rd_data);
        end
        // write r5 and mark it pending in the same cycle
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        issue_en = 1'b1; issue_addr = 5'd5;
        tick(); idle(); #1;
        checks++;
        if (rd_data[0 +: 32] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL r5_written: got %h exp deadbeef", rd_data[0 +: 32]);
        end
        checks++;
        if (busy_vec !== 32'h0000_0020) begin
            errors++; $display("FAIL r5_busy: got %h exp 00000020", busy_vec);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data[0 +: 32] !== 32'h0) begin
            errors++; $display("FAIL async_reset_data: got %h exp 0", rd_data[0 +: 32]);
        end
        checks++;
        if (busy_vec !== '0) begin
            errors++; $display("FAIL async_reset_busy: got %h exp 0", busy_vec);
        end
        // write and issue while reset is held must not take effect
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h12345678;
        issue_en = 1'b1; issue_addr = 5'd6;
        set_rd(5'd6, 5'd6, 5'd6);
        tick();
        checks++;
        if (rd_data[0 +: 32] !== 32'h0 || busy_vec !== '0) begin
            errors++; $display("FAIL write_in_reset: got data %h busy %h exp 0/0", rd_data[0 +: 32], busy_vec);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
        wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
        tick(); idle();
        set_rd(5'd7, 5'd0, 5'd0); #1;
        checks++;
        if (rd_data[0 +: 32] !== 32'h22222222) begin
            errors++; $display("FAIL same_addr_port1_wins: got %h exp 22222222", rd_data[0 +: 32]);
        end
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33333333;
        wen1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h44444444;
        tick(); idle();
        set_rd(5'd3, 5'd4, 5'd7); #1;
        checks++;
        if (rd_data[0 +: 32] !== 32'h33333333 || rd_data[32 +: 32] !== 32'h44444444) begin
            errors++; $display("FAIL diff_addr_both: got %h/%h exp 33333333/44444444",
                               rd_data[0 +: 32], rd_data[32 +: 32]);
        end
        checks++;
        if (rd_data[64 +: 32] !== 32'h22222222) begin
            errors++; $display("FAIL r7_kept: got %h exp 22222222", rd_data[64 +: 32]);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_addr = 5'd0;
        tick(); idle();
        set_rd(5'd0, 5'd0, 5'd0); #1;
        checks++;
        if (rd_data[0 +: 32] !== 32'h0 || busy_vec[0] !== 1'b0) begin
            errors++; $display("FAIL zero_reg: got data %h busy0 %b exp 0/0", rd_data[0 +: 32], busy_vec[0]);
        end
        checks++;
        if (rd_data_nz[0 +: 32] !== 32'hFFFFFFFF || busy_vec_nz[0] !== 1'b1) begin
            errors++; $display("FAIL plain_r0: got data %h busy0 %b exp ffffffff/1",
                               rd_data_nz[0 +: 32], busy_vec_nz[0]);
        end
        checks++;
        if (rd_busy !== 3'b000 || rd_busy_nz !== 3'b111) begin
            errors++; $display("FAIL r0_rd_busy: got %b/%b exp 000/111", rd_busy, rd_busy_nz);
        end
        @(negedge clk);
        wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h5A5A5A5A;
        tick(); idle(); #1;
        checks++;
        if (rd_data[0 +: 32] !== 32'h0 || rd_data_nz[32 +: 32] !== 32'h5A5A5A5A || busy_vec_nz[0] !== 1'b0) begin
            errors++; $display("FAIL r0_port1: got %h/%h busy %b exp 0/5a5a5a5a/0",
                               rd_data[0 +: 32], rd_data_nz[32 +: 32], busy_vec_nz[0]);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd9;
        set_rd(5'd0, 5'd9, 5'd8);
        #1;
        checks++;
        if (rd_busy !== 3'b000) begin
            errors++; $display("FAIL issue_not_early: got %b exp 000", rd_busy);
        end
        tick(); idle(); #1;
        checks++;
        if (rd_busy !== 3'b010 || busy_vec !== 32'h0000_0200) begin
            errors++; $display("FAIL issue_r9: got %b %h exp 010 00000200", rd_busy, busy_vec);
        end
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd9;
        wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99990000;
        tick(); idle(); #1;
        checks++;
        if (rd_busy[1] !== 1'b1) begin
            errors++; $display("FAIL issue_beats_retire: got %b exp 1", rd_busy[1]);
        end
        @(negedge clk);
        wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99991111;
        tick(); idle(); #1;
        checks++;
        if (rd_busy[1] !== 1'b0 || rd_data[32 +: 32] !== 32'h99991111) begin
            errors++; $display("FAIL retire_r9: got busy %b data %h exp 0/99991111", rd_busy[1], rd_data[32 +: 32]);
        end
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd10;
        tick();
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd11;
        tick();
        @(negedge clk);
        issue_en = 1'b0;
        wen0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hA;
        tick(); idle(); #1;
        checks++;
        if (busy_vec !== 32'h0000_0800) begin
            errors++; $display("FAIL retire_one_of_two: got %h exp 00000800", busy_vec);
        end
        @(negedge clk);
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd12;
        tick(); idle(); #1;
        checks++;
        if (busy_vec !== '0 || busy_vec_nz !== '0) begin
            errors++; $display("FAIL flush: got %h/%h exp 0/0", busy_vec, busy_vec_nz);
        end
    endtask

    task automatic test_read_ports();
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'd1;
        wen1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'd2;
        tick();
        @(negedge clk);
        idle();
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'd3;
        tick(); idle();
        set_rd(5'd1, 5'd2, 5'd3); #1;
        checks++;
        if (rd_data !== {32'd3, 32'd2, 32'd1}) begin
            errors++; $display("FAIL ports_123: got %h exp 000000030000000200000001", rd_data);
        end
        set_rd(5'd2, 5'd2, 5'd2); #1;
        checks++;
        if (rd_data !== {32'd2, 32'd2, 32'd2}) begin
            errors++; $display("FAIL ports_all_r2: got %h exp 000000020000000200000002", rd_data);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        logic [31:0] exp_both;
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h1234;
        tick(); idle();
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'hCAFE;
        set_rd(5'd6, 5'd0, 5'd5); #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hCAFE;
`else
        exp_same = 32'h1234;
`endif
        checks++;
        if (rd_data[0 +: 32] !== exp_same) begin
            errors++; $display("FAIL bypass_same_cycle: got %h exp %h", rd_data[0 +: 32], exp_same);
        end
        tick(); idle(); #1;
        checks++;
        if (rd_data[0 +: 32] !== 32'hCAFE) begin
            errors++; $display("FAIL bypass_next_cycle: got %h exp 0000cafe", rd_data[0 +: 32]);
        end
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'hAAAA;
        wen1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'hBBBB;
        issue_en = 1'b1; issue_addr = 5'd20;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_both = 32'hBBBB;
`else
        exp_both = 32'hCAFE;
`endif
        checks++;
        if (rd_data[0 +: 32] !== exp_both || rd_busy !== 3'b000) begin
            errors++; $display("FAIL bypass_port1_prio: got %h busy %b exp %h/000", rd_data[0 +: 32], rd_busy, exp_both);
        end
        tick(); idle();
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h55;
        #1;
        checks++;
        if (rd_data[32 +: 32] !== 32'h0 || rd_data[0 +: 32] !== 32'hBBBB) begin
            errors++; $display("FAIL bypass_zero: got %h/%h exp 0/0000bbbb", rd_data[32 +: 32], rd_data[0 +: 32]);
        end
        tick(); idle();
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = '0;
        idle();
        #12 rst_n = 1'b1;
        test_reset();
        test_dual_write();
        test_zero_reg();
        test_scoreboard();
        test_read_ports();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
